// File: rtl/body_temp_seg_scan_if.sv
// Data/display bundle for the body-temperature seven-segment scanner.
// master: upstream BCD stage plus display consumer; slave: the scanner itself.
interface body_temp_seg_scan_if;
    logic       data_valid;
    logic [3:0] body_temp_int_ten;
    logic [3:0] body_temp_int_one;
    logic [3:0] body_temp_dec_ten;
    logic [3:0] body_temp_dec_one;
    logic [7:0] body_temp_int;
    logic [7:0] body_temp_dec;
    logic [7:0] seg;
    logic [3:0] sel;
    logic       fever;

    modport master (
        output data_valid, body_temp_int_ten, body_temp_int_one,
               body_temp_dec_ten, body_temp_dec_one, body_temp_int, body_temp_dec,
        input  seg, sel, fever
    );

    modport slave (
        input  data_valid, body_temp_int_ten, body_temp_int_one,
               body_temp_dec_ten, body_temp_dec_one, body_temp_int, body_temp_dec,
        output seg, sel, fever
    );
endinterface

// File: rtl/body_temp_seg_scan.sv
// Double-buffered four-digit "TT.DD" common-anode scanner with leading-zero blanking.
// Define BODY_TEMP_FEVER_BLINK_EN to build the fever flag and the fever blink.
module body_temp_seg_scan #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                 clk,
    input  logic                 rst,
    body_temp_seg_scan_if.slave  bus
);
    localparam int DIV   = CLK_FREQ_HZ / DIGIT_HZ - 1;
    localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV + 1);
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return SEG_DASH;
        endcase
    endfunction

    logic [DIV_W-1:0] div_reg, div_next;
    logic [1:0]       idx_reg, idx_next;
    logic [15:0]      pend_digits_reg, pend_digits_next;
    logic             pending_ok_reg, pending_ok_next;
    logic [15:0]      disp_digits_reg, disp_digits_next;
    logic             disp_loaded_reg, disp_loaded_next;
    logic [7:0]       seg_reg, seg_next;
    logic [3:0]       sel_reg, sel_next;
    logic             tick;
    logic             frame_end;
    logic             blink_on;
    logic [15:0]      in_digits;
    logic [7:0]       digit_seg [4];

    assign in_digits = {bus.body_temp_int_ten, bus.body_temp_int_one,
                        bus.body_temp_dec_ten, bus.body_temp_dec_one};
    assign tick      = (div_reg == DIV_W'(DIV));
    assign frame_end = tick && (idx_reg == 2'd3);

    // Display only changes on a frame boundary; a coincident strobe bypasses pending.
    always_comb begin
        div_next         = tick ? '0 : div_reg + 1'b1;
        idx_next         = tick ? idx_reg + 2'd1 : idx_reg;
        pend_digits_next = pend_digits_reg;
        pending_ok_next  = pending_ok_reg;
        disp_digits_next = disp_digits_reg;
        disp_loaded_next = disp_loaded_reg;
        if (bus.data_valid) begin
            pend_digits_next = in_digits;
            pending_ok_next  = 1'b1;
        end
        if (frame_end) begin
            if (bus.data_valid) begin
                disp_digits_next = in_digits;
                disp_loaded_next = 1'b1;
            end else if (pending_ok_reg) begin
                disp_digits_next = pend_digits_reg;
                disp_loaded_next = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] bcd;
            logic [7:0] glyph;
            assign bcd   = disp_digits_reg[gi*4 +: 4];
            assign glyph = bcd_to_seg(bcd);
            if (gi == 3) begin : g_tens
                assign digit_seg[gi] = !disp_loaded_reg ? SEG_DASH :
                                       (bcd == 4'd0)    ? SEG_BLANK : glyph;
            end else if (gi == 2) begin : g_units
                // Decimal point sits after the integer units digit.
                assign digit_seg[gi] = !disp_loaded_reg ? SEG_DASH : (glyph & 8'h7F);
            end else begin : g_frac
                assign digit_seg[gi] = !disp_loaded_reg ? SEG_DASH : glyph;
            end
        end
    endgenerate

    always_comb begin
        sel_next = 4'(~(4'b0001 << idx_reg));
        seg_next = digit_seg[idx_reg];
        if (!blink_on) begin
            sel_next = 4'hF;
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg         <= '0;
            idx_reg         <= 2'd0;
            pend_digits_reg <= 16'h0000;
            pending_ok_reg  <= 1'b0;
            disp_digits_reg <= 16'h0000;
            disp_loaded_reg <= 1'b0;
            seg_reg         <= SEG_BLANK;
            sel_reg         <= 4'hF;
        end else begin
            div_reg         <= div_next;
            idx_reg         <= idx_next;
            pend_digits_reg <= pend_digits_next;
            pending_ok_reg  <= pending_ok_next;
            disp_digits_reg <= disp_digits_next;
            disp_loaded_reg <= disp_loaded_next;
            seg_reg         <= seg_next;
            sel_reg         <= sel_next;
        end
    end

    assign bus.seg = seg_reg;
    assign bus.sel = sel_reg;

`ifdef BODY_TEMP_FEVER_BLINK_EN
    localparam int BLK_W = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);

    logic [7:0]       pend_int_reg, pend_int_next;
    logic [7:0]       pend_dec_reg, pend_dec_next;
    logic [7:0]       disp_int_reg, disp_int_next;
    logic [7:0]       disp_dec_reg, disp_dec_next;
    logic             fever_reg, fever_next;
    logic [BLK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic             blink_on_reg, blink_on_next;

    // Binary copy follows exactly the same pending/display path as the digits.
    always_comb begin
        pend_int_next = pend_int_reg;
        pend_dec_next = pend_dec_reg;
        disp_int_next = disp_int_reg;
        disp_dec_next = disp_dec_reg;
        if (bus.data_valid) begin
            pend_int_next = bus.body_temp_int;
            pend_dec_next = bus.body_temp_dec;
        end
        if (frame_end) begin
            if (bus.data_valid) begin
                disp_int_next = bus.body_temp_int;
                disp_dec_next = bus.body_temp_dec;
            end else if (pending_ok_reg) begin
                disp_int_next = pend_int_reg;
                disp_dec_next = pend_dec_reg;
            end
        end
        fever_next = disp_loaded_reg &&
                     ((disp_int_reg > 8'd37) || ((disp_int_reg == 8'd37) && (disp_dec_reg >= 8'd30)));
    end

    // Blink phase steps only on frame boundaries so a frame is never half lit.
    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        blink_on_next  = blink_on_reg;
        if (frame_end) begin
            if (fever_reg) begin
                if (blink_cnt_reg == BLK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt_next = '0;
                    blink_on_next  = ~blink_on_reg;
                end else begin
                    blink_cnt_next = blink_cnt_reg + 1'b1;
                end
            end else begin
                blink_cnt_next = '0;
                blink_on_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_int_reg  <= 8'd0;
            pend_dec_reg  <= 8'd0;
            disp_int_reg  <= 8'd0;
            disp_dec_reg  <= 8'd0;
            fever_reg     <= 1'b0;
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else begin
            pend_int_reg  <= pend_int_next;
            pend_dec_reg  <= pend_dec_next;
            disp_int_reg  <= disp_int_next;
            disp_dec_reg  <= disp_dec_next;
            fever_reg     <= fever_next;
            blink_cnt_reg <= blink_cnt_next;
            blink_on_reg  <= blink_on_next;
        end
    end

    assign blink_on  = blink_on_reg;
    assign bus.fever = fever_reg;
`else
    assign blink_on  = 1'b1;
    assign bus.fever = 1'b0;
`endif
endmodule

// File: tb/tb_body_temp_seg_scan.sv
// Directed bench for body_temp_seg_scan at DIV = 3 (four cycles per digit, 16 per frame).
// Blink expectations follow BODY_TEMP_FEVER_BLINK_EN when it is defined for the build.
module tb_body_temp_seg_scan;
`ifdef BODY_TEMP_FEVER_BLINK_EN
    localparam bit FEV_EN = 1'b1;
`else
    localparam bit FEV_EN = 1'b0;
`endif
    localparam logic [31:0] ALL_DASH = 32'hBFBFBFBF;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    body_temp_seg_scan_if bus_if();

    body_temp_seg_scan #(
        .CLK_FREQ_HZ (4000),
        .DIGIT_HZ    (1000),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  d3, d2, d1, d0;
        logic [7:0]  bint, bdec;
        logic [31:0] exp_seg;   // {digit3, digit2, digit1, digit0}
        logic        exp_fever;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s tag=%0d actual=%h required=%h", name, tag, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [7:0] i, input logic [7:0] f, input int tag);
        @(posedge clk);
        #1;
        bus_if.body_temp_int_ten = a;
        bus_if.body_temp_int_one = b;
        bus_if.body_temp_dec_ten = c;
        bus_if.body_temp_dec_one = d;
        bus_if.body_temp_int     = i;
        bus_if.body_temp_dec     = f;
        bus_if.data_valid        = 1'b1;
        @(posedge clk);
        #1;
        bus_if.data_valid = 1'b0;
        $display("send tag=%0d digits=%h%h.%h%h bin=%0d.%0d", tag, a, b, c, d, i, f);
    endtask

    // Wait for the next visible frame start (sel turning 1110) and check all 16 cycles.
    task automatic check_frame(input logic [31:0] exp_seg, input logic exp_fever,
                               input int tag, output int waited);
        logic [3:0] prev;
        logic [3:0] exp_sel;
        bit         found;
        found  = 1'b0;
        waited = 0;
        prev   = bus_if.sel;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            waited++;
            if (bus_if.sel == 4'b1110 && prev != 4'b1110) begin
                found = 1'b1;
                break;
            end
            prev = bus_if.sel;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL frame_start tag=%0d actual=no_start required=start_within_200", tag);
        end else begin
            chk("frame_fever", tag, {31'd0, bus_if.fever}, {31'd0, exp_fever});
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < 4; c++) begin
                    if (k != 0 || c != 0) @(negedge clk);
                    exp_sel = 4'(~(4'b0001 << k));
                    chk("frame_digit", tag * 100 + k * 10 + c,
                        {20'd0, bus_if.sel, bus_if.seg}, {20'd0, exp_sel, exp_seg[k*8 +: 8]});
                end
            end
            $display("frame tag=%0d checked seg=%h fever=%0b", tag, exp_seg, exp_fever);
        end
    endtask

    initial begin
        int         waited;
        logic [3:0] prev;
        bit         found;

        total = 0;
        bad   = 0;
        vecs[0] = '{4'd3, 4'd6, 4'd5, 4'd0, 8'd36, 8'd50, 32'hB00292C0, 1'b0};
        vecs[1] = '{4'd0, 4'd5, 4'd0, 4'd0, 8'd5,  8'd0,  32'hFF12C0C0, 1'b0};
        vecs[2] = '{4'd1, 4'd2, 4'hA, 4'hF, 8'd12, 8'd0,  32'hF924BFBF, 1'b0};
        vecs[3] = '{4'd2, 4'd8, 4'd7, 4'd4, 8'd28, 8'd74, 32'hA400F899, 1'b0};
        vecs[4] = '{4'd3, 4'd7, 4'd2, 4'd9, 8'd37, 8'd29, 32'hB078A490, 1'b0};

        rst = 1'b1;
        bus_if.data_valid        = 1'b0;
        bus_if.body_temp_int_ten = 4'd0;
        bus_if.body_temp_int_one = 4'd0;
        bus_if.body_temp_dec_ten = 4'd0;
        bus_if.body_temp_dec_one = 4'd0;
        bus_if.body_temp_int     = 8'd0;
        bus_if.body_temp_dec     = 8'd0;

        // Reset state and the first two cycles after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 0, {19'd0, bus_if.fever, bus_if.sel, bus_if.seg}, {19'd0, 1'b0, 4'hF, 8'hFF});
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_cycle", 1, {20'd0, bus_if.sel, bus_if.seg}, {20'd0, 4'hF, 8'hFF});
        check_frame(ALL_DASH, 1'b0, 2, waited);
        chk("second_cycle_start", 2, waited, 1);
        check_frame(ALL_DASH, 1'b0, 3, waited);
        check_frame(ALL_DASH, 1'b0, 4, waited);

        // Table of single updates.
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0, vecs[v].bint, vecs[v].bdec, 10 + v);
            check_frame(vecs[v].exp_seg, vecs[v].exp_fever, 10 + v, waited);
        end

        // Strobe exactly on the frame-end edge, then another two cycles later.
        prev  = bus_if.sel;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus_if.sel == 4'b0111 && prev != 4'b0111) begin
                found = 1'b1;
                break;
            end
            prev = bus_if.sel;
        end
        chk("align_digit3", 20, {31'd0, found}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus_if.body_temp_int_ten = 4'd1;
        bus_if.body_temp_int_one = 4'd2;
        bus_if.body_temp_dec_ten = 4'd3;
        bus_if.body_temp_dec_one = 4'd4;
        bus_if.body_temp_int     = 8'd12;
        bus_if.body_temp_dec     = 8'd34;
        bus_if.data_valid        = 1'b1;
        @(posedge clk);
        #1 bus_if.data_valid = 1'b0;
        $display("send tag=21 digits=12.34 on frame end");
        fork
            check_frame(32'hF924B099, 1'b0, 21, waited);
            begin
                @(posedge clk);
                #1;
                bus_if.body_temp_int_ten = 4'd0;
                bus_if.body_temp_int_one = 4'd0;
                bus_if.body_temp_dec_ten = 4'd0;
                bus_if.body_temp_dec_one = 4'd1;
                bus_if.body_temp_int     = 8'd0;
                bus_if.body_temp_dec     = 8'd1;
                bus_if.data_valid        = 1'b1;
                @(posedge clk);
                #1 bus_if.data_valid = 1'b0;
                $display("send tag=22 digits=00.01 two cycles later");
            end
        join
        check_frame(32'hFF40C0F9, 1'b0, 22, waited);

        // Fever threshold and blink cadence.
        send(4'd3, 4'd7, 4'd3, 4'd0, 8'd37, 8'd30, 30);
        check_frame(32'hB078B0C0, FEV_EN, 30, waited);
        check_frame(32'hB078B0C0, FEV_EN, 31, waited);
`ifdef BODY_TEMP_FEVER_BLINK_EN
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            chk("blink_off", 3200 + c, {19'd0, bus_if.fever, bus_if.sel, bus_if.seg}, {19'd0, 1'b1, 4'hF, 8'hFF});
        end
`else
        check_frame(32'hB078B0C0, 1'b0, 32, waited);
        check_frame(32'hB078B0C0, 1'b0, 33, waited);
`endif
        check_frame(32'hB078B0C0, FEV_EN, 34, waited);
        send(4'd3, 4'd7, 4'd2, 4'd9, 8'd37, 8'd29, 35);
        check_frame(32'hB078A490, 1'b0, 35, waited);
        check_frame(32'hB078A490, 1'b0, 36, waited);

        // Reset in mid-frame drops both buffers.
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midframe_reset", 40, {19'd0, bus_if.fever, bus_if.sel, bus_if.seg}, {19'd0, 1'b0, 4'hF, 8'hFF});
        @(posedge clk);
        #1 rst = 1'b0;
        check_frame(ALL_DASH, 1'b0, 41, waited);
        check_frame(ALL_DASH, 1'b0, 42, waited);
        send(vecs[3].d3, vecs[3].d2, vecs[3].d1, vecs[3].d0, vecs[3].bint, vecs[3].bdec, 43);
        check_frame(vecs[3].exp_seg, 1'b0, 43, waited);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
